// File: rtl/comment_strip.sv
// Character-stream preprocessor: strips C line and block comments, optionally
// maps CR/LF to space, and emits the cleaned stream through a 2-entry queue.
module comment_strip #(
   parameter bit NORM_WS = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] in,
   input  logic       in_valid,
   output logic [7:0] out,
   output logic       out_valid,
   output logic       in_comment
);

   localparam int unsigned CHAR_W = 8;
   localparam int unsigned CNT_W  = 2;
   localparam int unsigned VCNT_W = 3;

   localparam logic [CHAR_W-1:0] CH_SLASH = 8'h2F;
   localparam logic [CHAR_W-1:0] CH_STAR  = 8'h2A;
   localparam logic [CHAR_W-1:0] CH_LF    = 8'h0A;
   localparam logic [CHAR_W-1:0] CH_CR    = 8'h0D;
   localparam logic [CHAR_W-1:0] CH_SP    = 8'h20;

   typedef enum logic [2:0] {
      NORMAL,
      SLASH,
      LINE,
      BLOCK,
      BLOCK_STAR
   } state_t;

   state_t                 state_q, state_d;
   logic [1:0][CHAR_W-1:0] q_data_q, q_data_d;
   logic [CNT_W-1:0]       q_cnt_q, q_cnt_d;
   logic [CHAR_W-1:0]      out_d;
   logic                   out_valid_d;
   logic                   in_comment_d;

   logic [CNT_W-1:0]       push_cnt;
   logic [CHAR_W-1:0]      push_a, push_b;
   logic [2:0][CHAR_W-1:0] v;
   logic [VCNT_W-1:0]      v_cnt;
   logic [VCNT_W-1:0]      v_rem;

   function automatic logic [CHAR_W-1:0] ws_map(input logic [CHAR_W-1:0] c);
      if (NORM_WS && (c == CH_LF || c == CH_CR)) return CH_SP;
      return c;
   endfunction

   // State, queue and output registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= NORMAL;
         q_data_q   <= '0;
         q_cnt_q    <= '0;
         out        <= '0;
         out_valid  <= 1'b0;
         in_comment <= 1'b0;
      end else begin
         state_q    <= state_d;
         q_data_q   <= q_data_d;
         q_cnt_q    <= q_cnt_d;
         out        <= out_d;
         out_valid  <= out_valid_d;
         in_comment <= in_comment_d;
      end
   end

   // Next state and characters pushed for the accepted input.
   always_comb begin
      state_d  = state_q;
      push_cnt = '0;
      push_a   = '0;
      push_b   = '0;
      if (in_valid) begin
         case (state_q)
            NORMAL: begin
               if (in == CH_SLASH) begin
                  state_d = SLASH;
               end else begin
                  push_cnt = CNT_W'(1);
                  push_a   = ws_map(in);
               end
            end
            SLASH: begin
               if (in == CH_SLASH) begin
                  state_d = LINE;
               end else if (in == CH_STAR) begin
                  state_d = BLOCK;
               end else begin
                  // The held '/' was not a comment opener: release it first.
                  push_cnt = CNT_W'(2);
                  push_a   = CH_SLASH;
                  push_b   = ws_map(in);
                  state_d  = NORMAL;
               end
            end
            LINE: begin
               if (in == CH_LF) begin
                  state_d  = NORMAL;
                  push_cnt = CNT_W'(1);
                  push_a   = ws_map(CH_LF);
               end
            end
            BLOCK: begin
               if (in == CH_STAR) state_d = BLOCK_STAR;
            end
            BLOCK_STAR: begin
               if (in == CH_SLASH) begin
                  state_d  = NORMAL;
                  push_cnt = CNT_W'(1);
                  push_a   = CH_SP;
               end else if (in != CH_STAR) begin
                  state_d = BLOCK;
               end
            end
            default: state_d = NORMAL;
         endcase
      end
   end

   // Queue contents followed by this cycle's pushes; the head goes to out.
   always_comb begin
      v     = '0;
      v_cnt = VCNT_W'(q_cnt_q) + VCNT_W'(push_cnt);
      case (q_cnt_q)
         CNT_W'(0): begin
            v[0] = push_a;
            v[1] = push_b;
         end
         CNT_W'(1): begin
            v[0] = q_data_q[0];
            v[1] = push_a;
            v[2] = push_b;
         end
         default: begin
            v[0] = q_data_q[0];
            v[1] = q_data_q[1];
            v[2] = push_a;
         end
      endcase

      out_valid_d = (v_cnt != '0);
      out_d       = out_valid_d ? v[0] : '0;
      q_data_d[0] = v[1];
      q_data_d[1] = v[2];
      v_rem       = out_valid_d ? (v_cnt - VCNT_W'(1)) : '0;
      q_cnt_d     = (v_rem > VCNT_W'(2)) ? CNT_W'(2) : CNT_W'(v_rem);

      in_comment_d = (state_d == LINE) || (state_d == BLOCK) ||
                     (state_d == BLOCK_STAR);
   end

endmodule
